// File: rtl/commit_trace_buffer.sv
// Retirement monitor: classifies committed instructions from NUM_CH lanes,
// stamps them with an instruction number and queues them in a FIFO drained
// over a valid/ready port. Also tracks cycle/instruction/drop counters, a
// watchdog and a RUN -> DRAIN -> DONE state machine.
module commit_trace_buffer #(
  parameter int unsigned NUM_CH     = 2,
  parameter int unsigned DATA_W     = 16,
  parameter int unsigned DEPTH      = 16,
  parameter int unsigned CNT_W      = 32,
  parameter int unsigned MAX_CYCLES = 100000
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic [NUM_CH-1:0]                     c_valid,
  input  logic [NUM_CH*DATA_W-1:0]              c_pc,
  input  logic [NUM_CH-1:0]                     c_regwrite,
  input  logic [NUM_CH*4-1:0]                   c_wreg,
  input  logic [NUM_CH*DATA_W-1:0]              c_wdata,
  input  logic [NUM_CH-1:0]                     c_memread,
  input  logic [NUM_CH-1:0]                     c_memwrite,
  input  logic [NUM_CH*DATA_W-1:0]              c_memaddr,
  input  logic [NUM_CH*DATA_W-1:0]              c_memdata,
  input  logic [NUM_CH-1:0]                     c_halt,
  output logic                                  rec_valid,
  input  logic                                  rec_ready,
  output logic [3+CNT_W+DATA_W+4+2*DATA_W-1:0]  rec_data,
  output logic [CNT_W-1:0]                      cycle_count,
  output logic [CNT_W-1:0]                      inst_count,
  output logic [CNT_W-1:0]                      drop_count,
  output logic                                  overflow,
  output logic                                  timeout,
  output logic                                  done
);

  localparam int unsigned REC_W  = 3 + CNT_W + DATA_W + 4 + 2 * DATA_W;
  localparam int unsigned PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_FW = $clog2(DEPTH) + 1;
  localparam int unsigned LANE_W = $clog2(NUM_CH + 1);

  localparam logic [2:0] KindNop   = 3'd0;
  localparam logic [2:0] KindLoad  = 3'd1;
  localparam logic [2:0] KindReg   = 3'd2;
  localparam logic [2:0] KindStore = 3'd3;
  localparam logic [2:0] KindHalt  = 3'd4;

  localparam logic [CNT_W-1:0]  WdLimit   = CNT_W'(MAX_CYCLES - 1);
  localparam logic [CNT_FW-1:0] DepthFull = CNT_FW'(DEPTH);

  typedef enum logic [1:0] {StRun, StDrain, StDone} state_e;

  state_e                 state_q, state_d;
  logic [REC_W-1:0]       mem_q [DEPTH];
  logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_FW-1:0]      count_q, count_d;
  logic [CNT_W-1:0]       cycle_q, cycle_d, inst_q, inst_d, drop_q, drop_d;
  logic                   overflow_q, overflow_d, timeout_q, timeout_d;

  logic [REC_W-1:0]       lane_rec  [NUM_CH];
  logic [PTR_W-1:0]       lane_slot [NUM_CH];
  logic [NUM_CH-1:0]      lane_push;
  logic [LANE_W-1:0]      n_proc, n_push, n_drop;
  logic                   halt_seen, stopped, pop, wd_fire;
  logic [CNT_FW-1:0]      free_slots;
  logic [CNT_W:0]         drop_sum;

  // Classify one lane into a packed record; priority HALT > LOAD > REG > STORE > NOP.
  function automatic logic [REC_W-1:0] build_rec(
    input logic              halt, rw, mr, mw,
    input logic [3:0]        wreg,
    input logic [DATA_W-1:0] pc, wdata, maddr, mdata,
    input logic [CNT_W-1:0]  inum
  );
    logic [2:0]        kind;
    logic [3:0]        rg;
    logic [DATA_W-1:0] val, addr;
    kind = KindNop;
    rg   = '0;
    val  = '0;
    addr = '0;
    if (halt) begin
      kind = KindHalt;
    end else if (rw && mr) begin
      kind = KindLoad;
      rg   = wreg;
      val  = wdata;
      addr = maddr;
    end else if (rw) begin
      kind = KindReg;
      rg   = wreg;
      val  = wdata;
    end else if (mw) begin
      kind = KindStore;
      val  = mdata;
      addr = maddr;
    end
    return {kind, inum, pc, rg, val, addr};
  endfunction

  assign pop = rec_valid && rec_ready;

  // Walk lanes in order: number them, push while space remains, stop after a halt.
  always_comb begin
    n_proc     = '0;
    n_push     = '0;
    n_drop     = '0;
    halt_seen  = 1'b0;
    stopped    = 1'b0;
    lane_push  = '0;
    // Space is sampled before any pop this cycle.
    free_slots = DepthFull - count_q;
    for (int i = 0; i < NUM_CH; i++) begin
      lane_rec[i]  = '0;
      lane_slot[i] = '0;
      if (state_q == StRun && !stopped && c_valid[i]) begin
        lane_rec[i] = build_rec(c_halt[i], c_regwrite[i], c_memread[i], c_memwrite[i],
                                c_wreg[i*4 +: 4], c_pc[i*DATA_W +: DATA_W],
                                c_wdata[i*DATA_W +: DATA_W], c_memaddr[i*DATA_W +: DATA_W],
                                c_memdata[i*DATA_W +: DATA_W], inst_q + CNT_W'(n_proc));
        if (CNT_FW'(n_push) < free_slots) begin
          lane_push[i] = 1'b1;
          lane_slot[i] = wr_ptr_q + PTR_W'(n_push);
          n_push       = n_push + 1'b1;
        end else begin
          n_drop = n_drop + 1'b1;
        end
        n_proc = n_proc + 1'b1;
        if (c_halt[i]) begin
          stopped   = 1'b1;
          halt_seen = 1'b1;
        end
      end
    end
  end

  // Counters, flags and FIFO pointers.
  always_comb begin
    wr_ptr_d   = wr_ptr_q + PTR_W'(n_push);
    rd_ptr_d   = rd_ptr_q + PTR_W'(pop);
    count_d    = count_q + CNT_FW'(n_push) - CNT_FW'(pop);
    inst_d     = inst_q + CNT_W'(n_proc);
    drop_sum   = {1'b0, drop_q} + (CNT_W + 1)'(n_drop);
    drop_d     = drop_sum[CNT_W] ? '1 : drop_sum[CNT_W-1:0];
    overflow_d = overflow_q | (n_drop != '0);
    cycle_d    = cycle_q;
    wd_fire    = 1'b0;
    if (state_q == StRun && cycle_q != '1) begin
      cycle_d = cycle_q + 1'b1;
      wd_fire = (cycle_q == WdLimit);
    end
    timeout_d  = timeout_q | wd_fire;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StRun:   if (halt_seen || wd_fire) state_d = StDrain;
      StDrain: if (count_d == '0) state_d = StDone;
      StDone:  state_d = StDone;
      default: state_d = StRun;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StRun;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      cycle_q    <= '0;
      inst_q     <= '0;
      drop_q     <= '0;
      overflow_q <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      cycle_q    <= cycle_d;
      inst_q     <= inst_d;
      drop_q     <= drop_d;
      overflow_q <= overflow_d;
      timeout_q  <= timeout_d;
    end
  end

  // FIFO storage; unreset since reads are gated by the occupancy count.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_CH; i++) begin
      if (lane_push[i]) mem_q[lane_slot[i]] <= lane_rec[i];
    end
  end

  // Outputs.
  always_comb begin
    rec_valid   = (count_q != '0);
    rec_data    = rec_valid ? mem_q[rd_ptr_q] : '0;
    done        = (state_q == StDone);
    cycle_count = cycle_q;
    inst_count  = inst_q;
    drop_count  = drop_q;
    overflow    = overflow_q;
    timeout     = timeout_q;
  end

endmodule

// File: tb/tb_commit_trace_buffer.sv
// Randomized and directed bench for commit_trace_buffer with a queue-based
// reference model and a decoupled scoreboard monitor on the record port.
module tb_commit_trace_buffer;

  localparam int NUM_CH     = 2;
  localparam int DATA_W     = 16;
  localparam int DEPTH      = 16;
  localparam int CNT_W      = 32;
  localparam int MAX_CYCLES = 20;
  localparam int REC_W      = 3 + CNT_W + DATA_W + 4 + 2 * DATA_W;

  logic                         clk = 1'b0;
  logic                         rst_n = 1'b0;
  logic [NUM_CH-1:0]            c_valid, c_regwrite, c_memread, c_memwrite, c_halt;
  logic [NUM_CH*DATA_W-1:0]     c_pc, c_wdata, c_memaddr, c_memdata;
  logic [NUM_CH*4-1:0]          c_wreg;
  logic                         rec_valid;
  logic                         rec_ready;
  logic [REC_W-1:0]             rec_data;
  logic [CNT_W-1:0]             cycle_count, inst_count, drop_count;
  logic                         overflow, timeout, done;

  commit_trace_buffer #(
    .NUM_CH(NUM_CH), .DATA_W(DATA_W), .DEPTH(DEPTH), .CNT_W(CNT_W), .MAX_CYCLES(MAX_CYCLES)
  ) dut (
    .clk(clk), .rst_n(rst_n), .c_valid(c_valid), .c_pc(c_pc), .c_regwrite(c_regwrite),
    .c_wreg(c_wreg), .c_wdata(c_wdata), .c_memread(c_memread), .c_memwrite(c_memwrite),
    .c_memaddr(c_memaddr), .c_memdata(c_memdata), .c_halt(c_halt), .rec_valid(rec_valid),
    .rec_ready(rec_ready), .rec_data(rec_data), .cycle_count(cycle_count),
    .inst_count(inst_count), .drop_count(drop_count), .overflow(overflow),
    .timeout(timeout), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]        kind;
    logic [CNT_W-1:0]  inum;
    logic [DATA_W-1:0] pc;
    logic [3:0]        rg;
    logic [DATA_W-1:0] val;
    logic [DATA_W-1:0] addr;
  } exp_t;

  exp_t sb[$];

  // Reference model state: 0 = running, 1 = draining, 2 = finished.
  int               m_state;
  int               m_cnt;
  logic [CNT_W-1:0] m_cycle, m_inst, m_drop;
  bit               m_ovf, m_tmo;

  int n_vec  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic exp_t mk(input int i);
    exp_t e;
    e.kind = 3'd0;
    e.inum = '0;
    e.pc   = c_pc[i*DATA_W +: DATA_W];
    e.rg   = '0;
    e.val  = '0;
    e.addr = '0;
    if (c_halt[i]) e.kind = 3'd4;
    else if (c_regwrite[i] && c_memread[i]) begin
      e.kind = 3'd1; e.rg = c_wreg[i*4 +: 4];
      e.val = c_wdata[i*DATA_W +: DATA_W]; e.addr = c_memaddr[i*DATA_W +: DATA_W];
    end else if (c_regwrite[i]) begin
      e.kind = 3'd2; e.rg = c_wreg[i*4 +: 4]; e.val = c_wdata[i*DATA_W +: DATA_W];
    end else if (c_memwrite[i]) begin
      e.kind = 3'd3; e.val = c_memdata[i*DATA_W +: DATA_W];
      e.addr = c_memaddr[i*DATA_W +: DATA_W];
    end
    return e;
  endfunction

  // Advance the model across the coming rising edge using the current inputs.
  task automatic model_step();
    bit pop;
    int free_n, pushed, nproc;
    bit halted, wd;
    exp_t e;
    pop = (m_cnt > 0) && rec_ready;
    if (m_state == 0) begin
      free_n = DEPTH - m_cnt;
      pushed = 0;
      nproc  = 0;
      halted = 0;
      for (int i = 0; i < NUM_CH; i++) begin
        if (!halted && c_valid[i]) begin
          e = mk(i);
          e.inum = m_inst + CNT_W'(nproc);
          nproc++;
          if (pushed < free_n) begin
            sb.push_back(e);
            pushed++;
          end else begin
            if (m_drop != '1) m_drop = m_drop + 1;
            m_ovf = 1;
          end
          if (c_halt[i]) halted = 1;
        end
      end
      m_inst = m_inst + CNT_W'(nproc);
      wd = 0;
      if (m_cycle != '1) begin
        wd = (m_cycle == CNT_W'(MAX_CYCLES - 1));
        m_cycle = m_cycle + 1;
      end
      if (wd) m_tmo = 1;
      m_cnt = m_cnt + pushed - int'(pop);
      if (halted || wd) m_state = 1;
    end else if (m_state == 1) begin
      m_cnt = m_cnt - int'(pop);
      if (m_cnt == 0) m_state = 2;
    end
  endtask

  // Compare DUT status against the model, then step one clock.
  task automatic tick();
    chk("rec_valid", 64'(rec_valid), 64'(m_cnt > 0));
    chk("cycle_count", 64'(cycle_count), 64'(m_cycle));
    chk("inst_count", 64'(inst_count), 64'(m_inst));
    chk("drop_count", 64'(drop_count), 64'(m_drop));
    chk("overflow", 64'(overflow), 64'(m_ovf));
    chk("timeout", 64'(timeout), 64'(m_tmo));
    chk("done", 64'(done), 64'(m_state == 2));
    model_step();
    @(negedge clk);
  endtask

  task automatic clear_lanes();
    c_valid = '0; c_regwrite = '0; c_memread = '0; c_memwrite = '0; c_halt = '0;
    c_pc = '0; c_wdata = '0; c_memaddr = '0; c_memdata = '0; c_wreg = '0;
  endtask

  task automatic set_lane(input int i, input bit rw, input bit mr, input bit mw, input bit h,
                          input logic [3:0] wreg, input logic [15:0] pc, input logic [15:0] wd,
                          input logic [15:0] ma, input logic [15:0] md);
    c_valid[i] = 1'b1; c_regwrite[i] = rw; c_memread[i] = mr; c_memwrite[i] = mw;
    c_halt[i] = h; c_wreg[i*4 +: 4] = wreg; c_pc[i*DATA_W +: DATA_W] = pc;
    c_wdata[i*DATA_W +: DATA_W] = wd; c_memaddr[i*DATA_W +: DATA_W] = ma;
    c_memdata[i*DATA_W +: DATA_W] = md;
  endtask

  task automatic rand_lanes();
    for (int i = 0; i < NUM_CH; i++) begin
      c_valid[i] = 1'($urandom); c_regwrite[i] = 1'($urandom);
      c_memread[i] = 1'($urandom); c_memwrite[i] = 1'($urandom);
      c_halt[i] = ($urandom_range(15) == 0);
      c_wreg[i*4 +: 4] = 4'($urandom); c_pc[i*DATA_W +: DATA_W] = 16'($urandom);
      c_wdata[i*DATA_W +: DATA_W] = 16'($urandom);
      c_memaddr[i*DATA_W +: DATA_W] = 16'($urandom);
      c_memdata[i*DATA_W +: DATA_W] = 16'($urandom);
    end
  endtask

  // Called at a falling edge: async reset mid-cycle, check, release, resync.
  task automatic do_reset();
    #3;
    rst_n = 1'b0;
    #1;
    chk("rst_rec_valid", 64'(rec_valid), 64'd0);
    chk("rst_rec_data", 64'(rec_data), 64'd0);
    chk("rst_cycle", 64'(cycle_count), 64'd0);
    chk("rst_inst", 64'(inst_count), 64'd0);
    chk("rst_drop", 64'(drop_count), 64'd0);
    chk("rst_flags", {61'd0, overflow, timeout, done}, 64'd0);
    m_state = 0; m_cnt = 0; m_cycle = '0; m_inst = '0; m_drop = '0; m_ovf = 0; m_tmo = 0;
    sb.delete();
    clear_lanes();
    rec_ready = 1'b0;
    @(negedge clk);
    #3;
    rst_n = 1'b1;
    // One rising edge falls between release and the next falling edge.
    model_step();
    @(negedge clk);
  endtask

  task automatic run_to_done();
    clear_lanes();
    rec_ready = 1'b1;
    for (int k = 0; k < 80 && m_state != 2; k++) tick();
    tick();
    chk("reached_done", 64'(done), 64'd1);
  endtask

  // Scoreboard monitor: head record must match the oldest expected entry.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (rst_n && rec_valid) begin
        if (sb.size() == 0) begin
          n_vec++;
          n_fail++;
          $display("FAIL sb_empty: rec_valid=1 with no expected record at %0t", $time);
        end else begin
          e = sb[0];
          chk("rec_kind", 64'(rec_data[REC_W-1 -: 3]), 64'(e.kind));
          chk("rec_inum", 64'(rec_data[REC_W-4 -: CNT_W]), 64'(e.inum));
          chk("rec_pc", 64'(rec_data[3*DATA_W+4-1 -: DATA_W]), 64'(e.pc));
          chk("rec_reg", 64'(rec_data[2*DATA_W+3 -: 4]), 64'(e.rg));
          chk("rec_value", 64'(rec_data[2*DATA_W-1 -: DATA_W]), 64'(e.val));
          chk("rec_addr", 64'(rec_data[DATA_W-1:0]), 64'(e.addr));
          if (rec_ready) void'(sb.pop_front());
        end
      end
    end
  end

  initial begin
    clear_lanes();
    rec_ready = 1'b0;
    m_state = 0; m_cnt = 0; m_cycle = '0; m_inst = '0; m_drop = '0; m_ovf = 0; m_tmo = 0;
    @(negedge clk);
    #3;
    rst_n = 1'b1;
    model_step();
    @(negedge clk);

    // Single REG commit on lane 0.
    do_reset();
    set_lane(0, 1, 0, 0, 0, 4'd3, 16'h0004, 16'h1234, 16'h0, 16'h0);
    tick();
    clear_lanes();
    tick();
    chk("t1_valid", 64'(rec_valid), 64'd1);
    chk("t1_inst", 64'(inst_count), 64'd1);
    rec_ready = 1'b1;
    tick();

    // LOAD on lane 0 plus STORE on lane 1 in the same cycle.
    do_reset();
    rec_ready = 1'b1;
    set_lane(0, 1, 1, 0, 0, 4'd5, 16'h0010, 16'hBEEF, 16'h0040, 16'h0);
    set_lane(1, 0, 0, 1, 0, 4'd7, 16'h0014, 16'h5555, 16'h0042, 16'h00AA);
    tick();
    clear_lanes();
    tick();
    tick();
    chk("t2_inst", 64'(inst_count), 64'd2);

    // Overflow: 18 records into 16 entries with the consumer stalled.
    do_reset();
    for (int c = 0; c < 9; c++) begin
      for (int i = 0; i < NUM_CH; i++)
        set_lane(i, 1, 0, 0, 0, 4'($urandom), 16'($urandom), 16'($urandom), 16'h0, 16'h0);
      tick();
    end
    clear_lanes();
    tick();
    chk("t3_drop", 64'(drop_count), 64'd2);
    chk("t3_ovf", 64'(overflow), 64'd1);
    chk("t3_inst", 64'(inst_count), 64'd18);
    run_to_done();

    // Halt on lane 0 masks lane 1; later commits are ignored.
    do_reset();
    rec_ready = 1'b1;
    set_lane(0, 0, 0, 0, 1, 4'd0, 16'h0100, 16'h0, 16'h0, 16'h0);
    set_lane(1, 1, 0, 0, 0, 4'd9, 16'h0104, 16'h7777, 16'h0, 16'h0);
    tick();
    for (int c = 0; c < 6; c++) begin
      rand_lanes();
      tick();
    end
    chk("t4_inst", 64'(inst_count), 64'd1);
    chk("t4_done", 64'(done), 64'd1);

    // Watchdog with no halt.
    do_reset();
    rec_ready = 1'b1;
    for (int c = 0; c < 25; c++) tick();
    chk("t5_timeout", 64'(timeout), 64'd1);
    chk("t5_cycle", 64'(cycle_count), 64'(MAX_CYCLES));
    chk("t5_done", 64'(done), 64'd1);

    // Five records queued, then an asynchronous reset.
    do_reset();
    for (int c = 0; c < 2; c++) begin
      for (int i = 0; i < NUM_CH; i++)
        set_lane(i, 0, 0, 1, 0, 4'd0, 16'($urandom), 16'h0, 16'($urandom), 16'($urandom));
      tick();
    end
    clear_lanes();
    set_lane(0, 0, 0, 0, 0, 4'd0, 16'h0200, 16'h0, 16'h0, 16'h0);
    tick();
    clear_lanes();
    tick();
    chk("t6_inst", 64'(inst_count), 64'd5);
    do_reset();

    // Randomized phases.
    for (int r = 0; r < 8; r++) begin
      do_reset();
      for (int c = 0; c < 30; c++) begin
        rand_lanes();
        rec_ready = ($urandom_range(3) != 0);
        tick();
      end
      run_to_done();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/commit_trace_buffer.md
Name: commit_trace_buffer

Overview:
- Synthesizable retirement monitor for the pipelined CPU.
- Watches NUM_CH commit lanes per cycle and classifies each retired instruction as LOAD, REG, STORE, NOP or HALT.
- Stamps each record with its instruction number and queues it in a FIFO, drained over a valid/ready port.
- Also keeps cycle and instruction counters, a watchdog, an overflow flag and a halt/drain/done state machine, so trace checking works on pipelined and multi-issue cores without a behavioural bench.

Parameters:
- NUM_CH, 2, number of commit lanes per cycle (1..4).
- DATA_W, 16, width of PC, data and address fields.
- DEPTH, 16, FIFO entries (power of two, >= NUM_CH).
- CNT_W, 32, width of cycle/instruction counters and the inum field.
- MAX_CYCLES, 100000, watchdog limit in RUN cycles.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- c_valid  in  NUM_CH  lane i retires an instruction this cycle.
- c_pc  in  NUM_CH*DATA_W  PC per lane (lane i at bits [i*DATA_W +: DATA_W]; same packing for all per-lane buses).
- c_regwrite  in  NUM_CH  register write.
- c_wreg  in  NUM_CH*4  destination register.
- c_wdata  in  NUM_CH*DATA_W  register write data.
- c_memread  in  NUM_CH  memory read.
- c_memwrite  in  NUM_CH  memory write.
- c_memaddr  in  NUM_CH*DATA_W  memory address.
- c_memdata  in  NUM_CH*DATA_W  store data.
- c_halt  in  NUM_CH  halt retiring.
- rec_valid  out  1  FIFO head valid.
- rec_ready  in  1  consumer accepts the head record.
- rec_data  out  3+CNT_W+DATA_W+4+2*DATA_W  packed record {kind, inum, pc, reg, value, addr}.
- cycle_count  out  CNT_W  cycles spent in RUN.
- inst_count  out  CNT_W  retired instructions.
- drop_count  out  CNT_W  records lost to overflow.
- overflow  out  1  sticky; at least one record dropped.
- timeout  out  1  sticky; watchdog fired.
- done  out  1  state == DONE.

Behaviour:
- Reset (async, rst_n=0):
  - state=RUN; FIFO empty.
  - All counters 0; overflow, timeout and done 0.
  - rec_valid=0, rec_data=0.
- kind encoding, applied per valid lane in this priority order:
  - HALT=4 if c_halt.
  - LOAD=1 if regwrite&memread: reg=wreg, value=wdata, addr=memaddr.
  - REG=2 if regwrite: reg=wreg, value=wdata, addr=0.
  - STORE=3 if memwrite: reg=0, value=memdata, addr=memaddr.
  - NOP=0 otherwise: reg, value and addr all 0.
- inum assignment:
  - Valid lanes are processed in ascending index order.
  - The j-th valid lane in a cycle gets inum = inst_count + j (j from 0).
  - inst_count advances by the number of processed lanes, including dropped ones.
- Halt in a lane: lanes with a higher index in the same cycle are ignored (not counted, not pushed).
- Capture happens only in RUN. In DRAIN and DONE all c_* inputs are ignored.
- FIFO push:
  - Free space is taken from the occupancy at the start of the cycle; a same-cycle pop does not create space.
  - Records are pushed in lane order while space remains; the rest are dropped.
  - Each dropped record: drop_count++ (saturating) and overflow=1.
  - A dropped HALT still triggers the state transition.
- FIFO pop:
  - Pop when rec_valid&rec_ready.
  - rec_data is the registered head and is stable while rec_valid=1 and rec_ready=0.
  - Pop and push in the same cycle are both honoured; count changes by pushes-pops.
- Latency: a record committed in cycle N is visible on rec_valid in cycle N+1 if the FIFO was empty.
- Pointer wrap: modulo DEPTH; full/empty come from a separate count register of width log2(DEPTH)+1.
- cycle_count:
  - Increments by 1 each RUN cycle, saturating at all-ones.
  - Frozen in DRAIN and DONE.
- State machine:
  - RUN -> DRAIN when a HALT is processed, or when cycle_count == MAX_CYCLES-1 on an increment. The watchdog case also sets timeout=1.
  - DRAIN -> DONE when the FIFO is empty, or becomes empty by a pop this cycle.
  - DONE: terminal until reset; done=1 and the FIFO stays empty.
- Simultaneous halt and watchdog in the same cycle: halt records are captured and timeout=1; a single transition to DRAIN.
- Reset mid-operation: everything returns to reset values immediately; queued records are discarded.

Test Plan:
- Single REG lane0, pc=0x0004, wreg=3, wdata=0x1234 -> next cycle rec_valid=1, kind=2, inum=0, reg=3, value=0x1234, addr=0; inst_count=1.
- Same cycle lane0 LOAD (wreg=5, wdata=0xBEEF, addr=0x0040) and lane1 STORE (addr=0x0042, data=0x00AA) -> two records in order with inum 0 and 1 and the matching fields; inst_count=2.
- rec_ready=0, DEPTH=16, commit 9 cycles × 2 lanes -> first 16 queued, last 2 dropped; drop_count=2, overflow=1, inst_count=18, rec_data held constant.
- Lane0 HALT with lane1 REG valid in the same cycle, rec_ready=1 -> only the HALT record is pushed; inst_count+1; DRAIN, then done=1 the cycle after the FIFO empties; later commits ignored.
- MAX_CYCLES=20, no halt -> timeout=1 after 20 RUN cycles, cycle_count=20 frozen, done=1 once drained.
- Assert rst_n=0 with 5 records queued -> rec_valid=0, all counters 0 and flags 0 asynchronously, without waiting for a clock edge.
